// File: rtl/spi_pkg.sv
// spi_pkg - shared types and constants for the SPI RAM slave front end.
// Rev 1.0
`default_nettype none

package spi_pkg;

   localparam int FRAME_W_DEF = 10;
   localparam int DATA_W_DEF  = 8;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_CHK_CMD   = 3'd1;
   localparam logic [2:0] ST_WRITE     = 3'd2;
   localparam logic [2:0] ST_READ_ADD  = 3'd3;
   localparam logic [2:0] ST_READ_DATA = 3'd4;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      CHK_CMD   = ST_CHK_CMD,
      WRITE     = ST_WRITE,
      READ_ADD  = ST_READ_ADD,
      READ_DATA = ST_READ_DATA
   } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter - loads a read response and shifts it out MSB first on miso.
// Rev 1.0
`default_nettype none

module spi_tx_shifter
   import spi_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic [DATA_W-1:0] data,
   output logic              miso,
   output logic              busy,
   output logic              done
);

   localparam int CW = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] sr;
   logic [CW-1:0]     left;

   // The MSB goes straight to miso on load, so only DATA_W-1 bits remain queued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr   <= '0;
         left <= '0;
         miso <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else if (clear) begin
         sr   <= '0;
         left <= '0;
         miso <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else if (load) begin
         miso <= data[DATA_W-1];
         sr   <= {data[DATA_W-2:0], 1'b0};
         left <= CW'(DATA_W - 1);
         busy <= 1'b1;
         done <= 1'b0;
      end else if (busy) begin
         if (left != '0) begin
            miso <= sr[DATA_W-1];
            sr   <= {sr[DATA_W-2:0], 1'b0};
            left <= left - CW'(1);
         end else begin
            miso <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/spi_slave_if.sv
// spi_slave_if - SPI RAM slave serial front end; define SPI_FRAME_ERR_EN to add frame_err.
// Rev 1.0
`default_nettype none

module spi_slave_if
   import spi_pkg::*;
#(
   parameter int FRAME_W = FRAME_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ss_n,
   input  logic               mosi,
   input  logic [DATA_W-1:0]  tx_data,
   input  logic               tx_valid,
   output logic               miso,
   output logic [FRAME_W-1:0] rx_data,
   output logic               rx_valid
`ifdef SPI_FRAME_ERR_EN
   ,
   output logic               frame_err
`endif
);

   localparam int               CNT_W    = $clog2(FRAME_W + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

   spi_state_t         state;
   logic [CNT_W-1:0]   cnt;
   logic [FRAME_W-2:0] shift;
   logic               rd_addr_flag;
   logic               tx_busy;
   logic               tx_done;
   logic               awaiting;
   logic               tx_load;
   logic               tx_clear;
   logic               in_rx;

   assign in_rx    = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
   assign awaiting = (state == READ_DATA) && (cnt == CNT_FULL) && !tx_busy && !tx_done;
   // Abort wins over a response arriving in the same cycle.
   assign tx_load  = awaiting && tx_valid && !ss_n;
   assign tx_clear = (state != IDLE) && ss_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         shift        <= '0;
         rd_addr_flag <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (!ss_n) state <= CHK_CMD;
            end
            CHK_CMD: begin
               if (ss_n) begin
                  state <= IDLE;
                  cnt   <= '0;
                  shift <= '0;
               end else begin
                  shift <= {{(FRAME_W-2){1'b0}}, mosi};
                  cnt   <= CNT_W'(1);
                  if (mosi == CMD_WR_ADDR[1]) state <= WRITE;
                  else if (!rd_addr_flag)     state <= READ_ADD;
                  else                        state <= READ_DATA;
               end
            end
            WRITE, READ_ADD, READ_DATA: begin
               if (ss_n) begin
                  state <= IDLE;
                  cnt   <= '0;
                  shift <= '0;
               end else if (cnt != CNT_FULL) begin
                  shift <= {shift[FRAME_W-3:0], mosi};
                  cnt   <= cnt + CNT_W'(1);
                  if (cnt == CNT_LAST) begin
                     rx_data  <= {shift, mosi};
                     rx_valid <= 1'b1;
                     if (state == READ_ADD)       rd_addr_flag <= 1'b1;
                     else if (state == READ_DATA) rd_addr_flag <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               shift <= '0;
            end
         endcase
      end
   end

   spi_tx_shifter #(
      .DATA_W (DATA_W)
   ) u_tx (
      .clk   (clk),
      .rst   (rst),
      .clear (tx_clear),
      .load  (tx_load),
      .data  (tx_data),
      .miso  (miso),
      .busy  (tx_busy),
      .done  (tx_done)
   );

`ifdef SPI_FRAME_ERR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_err <= 1'b0;
      end else if (state == IDLE && !ss_n) begin
         frame_err <= 1'b0;
      end else if (ss_n && in_rx &&
                   ((cnt != CNT_FULL) || (state == READ_DATA && !tx_done))) begin
         frame_err <= 1'b1;
      end
   end
`else
   // Without the error flag the receive-state decode has no consumer.
   logic unused_in_rx;
   assign unused_in_rx = in_rx;
`endif

endmodule

`default_nettype wire
